ro_result_sender: RTL and testbench

- Static-region stage directly downstream of the ring-oscillator measurement logic and upstream of the PS-side interrupt/data interface.
- Buffers 32-bit measurement results in a FIFO and delivers them one word at a time to the PS: drives the word onto a 32-bit slot and pulses an interrupt line.
- Holds each word until the PS acknowledges it, and re-pulses the interrupt on an ack timeout.
- Honours the partial-reconfiguration DECOUPLE signal by ignoring its input side while the reconfigurable region is being swapped.

---
 rtl/ro_pkg.sv | 13 +
 rtl/ro_sync_fifo.sv | 58 +++++
 rtl/ro_result_sender.sv | 110 +++++++++++
 tb/tb_ro_result_sender.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ro_pkg.sv
// Shared definitions for the ring-oscillator result sender: default word width
// and the delivery FSM state encoding.
package ro_pkg;

   localparam int DEFAULT_DATA_WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SEND     = 2'd1,
      WAIT_ACK = 2'd2
   } state_t;

endpackage

// File: rtl/ro_sync_fifo.sv
// Single-clock FIFO with a registered (block-RAM style) read port. The exposed
// empty flag lags the pointers so that dout is always valid when empty is low.
module ro_sync_fifo
   import ro_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int DEPTH      = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    wr_en,
   input  logic [DATA_WIDTH-1:0]   din,
   input  logic                    rd_en,
   output logic [DATA_WIDTH-1:0]   dout,
   output logic                    full,
   output logic                    empty,
   output logic [$clog2(DEPTH):0]  level
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]           wr_ptr_reg;
   logic [AW:0]           rd_ptr_reg;
   logic                  empty_reg;
   logic                  ptr_empty;
   logic                  wr_ok;
   logic                  rd_ok;
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [DATA_WIDTH-1:0] dout_reg;

   assign ptr_empty = (wr_ptr_reg == rd_ptr_reg);
   assign full      = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                      (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
   assign level     = wr_ptr_reg - rd_ptr_reg;
   assign wr_ok     = wr_en && !full;
   assign rd_ok     = rd_en && !ptr_empty;
   assign empty     = empty_reg;
   assign dout      = dout_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         empty_reg  <= 1'b1;
      end else begin
         if (wr_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (rd_ok) rd_ptr_reg <= rd_ptr_reg + 1'b1;
         // A pop hides the next head for one cycle while the read register refills.
         empty_reg <= ptr_empty || rd_ok;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_ok) mem[wr_ptr_reg[AW-1:0]] <= din;
      dout_reg <= mem[rd_ptr_reg[AW-1:0]];
   end

endmodule

// File: rtl/ro_result_sender.sv
// Buffers measurement words and hands them to the PS one at a time with an
// interrupt pulse, holding each word until acknowledged and re-pulsing on timeout.
module ro_result_sender
   import ro_pkg::*;
#(
   parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
   parameter int DEPTH        = 16,
   parameter int RETRY_CYCLES = 1000000
) (
   input  logic                    CLK,
   input  logic                    RESETN,
   input  logic                    DECOUPLE,
   input  logic                    in_valid,
   input  logic [DATA_WIDTH-1:0]   in_data,
   output logic                    in_ready,
   output logic [DATA_WIDTH-1:0]   data_out,
   output logic                    intr_out,
   input  logic                    intr_ack,
   input  logic                    clr_ovf,
   output logic                    overflow,
   output logic [$clog2(DEPTH):0]  level
);

   localparam int             TW        = $clog2(RETRY_CYCLES);
   localparam logic [TW-1:0]  TIMER_MAX = TW'(RETRY_CYCLES - 1);
   localparam logic [TW-1:0]  TIMER_ONE = TW'(1);

   state_t                state_reg;
   state_t                state_next;
   logic [TW-1:0]         timer_reg;
   logic [DATA_WIDTH-1:0] data_out_reg;
   logic                  ovf_reg;
   logic                  ready_en_reg;
   logic                  pop;
   logic                  ovf_set;
   logic                  fifo_wr;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic [DATA_WIDTH-1:0] fifo_dout;

   // ready_en_reg keeps in_ready low until the first edge after reset release.
   assign in_ready = ready_en_reg && !fifo_full && !DECOUPLE;
   assign fifo_wr  = in_valid && in_ready;
   assign ovf_set  = in_valid && fifo_full && !DECOUPLE;
   assign intr_out = (state_reg == SEND);
   assign data_out = data_out_reg;
   assign overflow = ovf_reg;

   ro_sync_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
   ) u_fifo (
      .clk   (CLK),
      .rst_n (RESETN),
      .wr_en (fifo_wr),
      .din   (in_data),
      .rd_en (pop),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (level)
   );

   always_comb begin
      state_next = state_reg;
      pop        = 1'b0;
      case (state_reg)
         IDLE: begin
            if (!fifo_empty) begin
               pop        = 1'b1;
               state_next = SEND;
            end
         end
         SEND: begin
            state_next = intr_ack ? IDLE : WAIT_ACK;
         end
         WAIT_ACK: begin
            if (intr_ack)
               state_next = IDLE;
            else if (timer_reg == TIMER_MAX)
               state_next = SEND;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         state_reg    <= IDLE;
         timer_reg    <= '0;
         data_out_reg <= '0;
         ovf_reg      <= 1'b0;
         ready_en_reg <= 1'b0;
      end else begin
         state_reg    <= state_next;
         ready_en_reg <= 1'b1;
         if (state_reg == SEND)
            timer_reg <= '0;
         else if (state_reg == WAIT_ACK)
            timer_reg <= timer_reg + TIMER_ONE;
         if (pop)
            data_out_reg <= fifo_dout;
         if (ovf_set)
            ovf_reg <= 1'b1;
         else if (clr_ovf)
            ovf_reg <= 1'b0;
      end
   end

endmodule

// File: tb/tb_ro_result_sender.sv
// Directed bench for ro_result_sender: a vector table for the basic handshake
// plus hand-written sequences for decouple, burst/overflow, retry and reset.
module tb_ro_result_sender;

   localparam int DW = 32;

   logic          CLK;
   logic          RESETN;
   logic          DECOUPLE;
   logic          in_valid;
   logic [DW-1:0] in_data;
   logic          in_ready;
   logic [DW-1:0] data_out;
   logic          intr_out;
   logic          intr_ack;
   logic          clr_ovf;
   logic          overflow;
   logic [4:0]    level;

   int checks   = 0;
   int failures = 0;

   ro_result_sender #(
      .DATA_WIDTH   (DW),
      .DEPTH        (16),
      .RETRY_CYCLES (5)
   ) dut (
      .CLK      (CLK),
      .RESETN   (RESETN),
      .DECOUPLE (DECOUPLE),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (in_ready),
      .data_out (data_out),
      .intr_out (intr_out),
      .intr_ack (intr_ack),
      .clr_ovf  (clr_ovf),
      .overflow (overflow),
      .level    (level)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic          valid;
      logic [DW-1:0] din;
      logic          ack;
      logic          dec;
      logic          clr;
      logic          exp_intr;
      logic [DW-1:0] exp_data;
      logic [4:0]    exp_level;
      logic          exp_ovf;
      logic          exp_ready;
   } vec_t;

   vec_t vecs[16];

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic wait_intr(input string name);
      int n;
      n = 0;
      while (!intr_out && n < 40) begin
         tick();
         n++;
      end
      checks++;
      if (!intr_out) begin
         failures++;
         $display("FAIL %s: got no intr_out within 40 cycles, required a pulse", name);
      end
   endtask

   task automatic ack_pulse();
      intr_ack = 1'b1;
      tick();
      intr_ack = 1'b0;
   endtask

   initial begin
      // valid din ack dec clr | intr data level ovf ready
      vecs[0]  = '{1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        5'd1, 1'b0, 1'b1};
      vecs[1]  = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        5'd1, 1'b0, 1'b1};
      vecs[2]  = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 5'd0, 1'b0, 1'b1};
      vecs[3]  = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 5'd0, 1'b0, 1'b1};
      vecs[4]  = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 5'd0, 1'b0, 1'b1};
      vecs[5]  = '{1'b1, 32'h11111111, 1'b0, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 5'd1, 1'b0, 1'b1};
      vecs[6]  = '{1'b1, 32'h22222222, 1'b0, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 5'd2, 1'b0, 1'b1};
      vecs[7]  = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 32'h11111111, 5'd1, 1'b0, 1'b1};
      vecs[8]  = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 32'h11111111, 5'd1, 1'b0, 1'b1};
      vecs[9]  = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 32'h22222222, 5'd0, 1'b0, 1'b1};
      vecs[10] = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'h22222222, 5'd0, 1'b0, 1'b1};
      vecs[11] = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 32'h22222222, 5'd0, 1'b0, 1'b1};
      vecs[12] = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'h22222222, 5'd0, 1'b0, 1'b1};
      vecs[13] = '{1'b1, 32'h00000055, 1'b0, 1'b1, 1'b0, 1'b0, 32'h22222222, 5'd0, 1'b0, 1'b0};
      vecs[14] = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'h22222222, 5'd0, 1'b0, 1'b1};
      vecs[15] = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 32'h22222222, 5'd0, 1'b0, 1'b1};

      RESETN   = 1'b1;
      DECOUPLE = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      intr_ack = 1'b0;
      clr_ovf  = 1'b0;

      // Reset state
      #1 RESETN = 1'b0;
      #2;
      check("rst_data_out", data_out, 32'h0);
      check("rst_intr_out", {31'h0, intr_out}, 32'h0);
      check("rst_overflow", {31'h0, overflow}, 32'h0);
      check("rst_level", {27'h0, level}, 32'h0);
      check("rst_in_ready", {31'h0, in_ready}, 32'h0);
      #9 RESETN = 1'b1;
      #1;
      check("rel_in_ready_before_edge", {31'h0, in_ready}, 32'h0);
      tick();
      check("rel_in_ready_after_edge", {31'h0, in_ready}, 32'h1);

      // Vector table: single word, ack in SEND, back-to-back pop, decouple while empty
      for (int v = 0; v < 16; v++) begin
         in_valid = vecs[v].valid;
         in_data  = vecs[v].din;
         intr_ack = vecs[v].ack;
         DECOUPLE = vecs[v].dec;
         clr_ovf  = vecs[v].clr;
         tick();
         $display("vec %0d: intr=%0b data=0x%h level=%0d ovf=%0b ready=%0b",
                  v, intr_out, data_out, level, overflow, in_ready);
         check($sformatf("vec%0d_intr", v), {31'h0, intr_out}, {31'h0, vecs[v].exp_intr});
         check($sformatf("vec%0d_data", v), data_out, vecs[v].exp_data);
         check($sformatf("vec%0d_level", v), {27'h0, level}, {27'h0, vecs[v].exp_level});
         check($sformatf("vec%0d_ovf", v), {31'h0, overflow}, {31'h0, vecs[v].exp_ovf});
         check($sformatf("vec%0d_ready", v), {31'h0, in_ready}, {31'h0, vecs[v].exp_ready});
      end
      in_valid = 1'b0;
      intr_ack = 1'b0;
      DECOUPLE = 1'b0;
      clr_ovf  = 1'b0;

      // DECOUPLE with three words buffered
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         in_data  = 32'hA0 + 32'(i);
         tick();
      end
      in_valid = 1'b0;
      check("dec_level_before", {27'h0, level}, 32'd3);
      check("dec_data_first", data_out, 32'hA0);
      DECOUPLE = 1'b1;
      in_valid = 1'b1;
      in_data  = 32'h55;
      #1;
      check("dec_in_ready", {31'h0, in_ready}, 32'h0);
      for (int k = 1; k <= 3; k++) begin
         ack_pulse();
         wait_intr("dec_drain_intr");
         $display("decouple drain: data=0x%h level=%0d", data_out, level);
         check("dec_drain_data", data_out, 32'hA0 + 32'(k));
         check("dec_drain_level", {27'h0, level}, 32'(3 - k));
      end
      ack_pulse();
      tick();
      check("dec_no_write_level", {27'h0, level}, 32'h0);
      check("dec_no_overflow", {31'h0, overflow}, 32'h0);
      DECOUPLE = 1'b0;
      tick();
      in_valid = 1'b0;
      check("dec_release_level", {27'h0, level}, 32'd1);
      wait_intr("dec_release_intr");
      check("dec_release_data", data_out, 32'h55);
      ack_pulse();

      // Burst to full, ack held low
      for (int i = 0; i < 17; i++) begin
         check("burst_ready", {31'h0, in_ready}, 32'h1);
         in_valid = 1'b1;
         in_data  = 32'(i);
         tick();
      end
      in_valid = 1'b0;
      check("burst_level", {27'h0, level}, 32'd16);
      check("burst_in_ready", {31'h0, in_ready}, 32'h0);
      check("burst_overflow", {31'h0, overflow}, 32'h0);
      check("burst_data_out", data_out, 32'h0);
      in_valid = 1'b1;
      in_data  = 32'h99;
      tick();
      in_valid = 1'b0;
      check("ovf_set", {31'h0, overflow}, 32'h1);
      check("ovf_level_unchanged", {27'h0, level}, 32'd16);
      clr_ovf = 1'b1;
      tick();
      clr_ovf = 1'b0;
      check("ovf_clear", {31'h0, overflow}, 32'h0);
      in_valid = 1'b1;
      clr_ovf  = 1'b1;
      tick();
      in_valid = 1'b0;
      clr_ovf  = 1'b0;
      check("ovf_set_wins", {31'h0, overflow}, 32'h1);
      clr_ovf = 1'b1;
      tick();
      clr_ovf = 1'b0;
      check("ovf_clear_again", {31'h0, overflow}, 32'h0);
      for (int k = 0; k < 17; k++) begin
         wait_intr("burst_drain_intr");
         $display("burst drain: data=0x%h level=%0d", data_out, level);
         check("burst_drain_data", data_out, 32'(k));
         check("burst_drain_level", {27'h0, level}, 32'(16 - k));
         ack_pulse();
         if (k == 0)
            check("full_ready_pop_cycle", {31'h0, in_ready}, 32'h0);
      end

      // Retry every RETRY_CYCLES+1 cycles without ack
      in_valid = 1'b1;
      in_data  = 32'hCAFE0001;
      tick();
      in_valid = 1'b0;
      wait_intr("retry_first");
      for (int off = 1; off <= 13; off++) begin
         tick();
         check($sformatf("retry_intr_off%0d", off), {31'h0, intr_out},
               {31'h0, ((off % 6) == 0) ? 1'b1 : 1'b0});
         check("retry_data", data_out, 32'hCAFE0001);
      end
      ack_pulse();

      // Ack in WAIT_ACK stops further pulses
      in_valid = 1'b1;
      in_data  = 32'hCAFE0002;
      tick();
      in_valid = 1'b0;
      wait_intr("ackstop_first");
      tick();
      tick();
      intr_ack = 1'b1;
      tick();
      intr_ack = 1'b0;
      for (int i = 0; i < 14; i++) begin
         tick();
         check("ackstop_no_intr", {31'h0, intr_out}, 32'h0);
      end
      check("ackstop_data", data_out, 32'hCAFE0002);

      // Asynchronous reset mid-WAIT_ACK with five words buffered
      for (int i = 0; i < 6; i++) begin
         in_valid = 1'b1;
         in_data  = 32'hB0 + 32'(i);
         tick();
      end
      in_valid = 1'b0;
      check("rst2_level_before", {27'h0, level}, 32'd5);
      check("rst2_data_before", data_out, 32'hB0);
      #3 RESETN = 1'b0;
      #1;
      check("rst2_data_out", data_out, 32'h0);
      check("rst2_intr_out", {31'h0, intr_out}, 32'h0);
      check("rst2_level", {27'h0, level}, 32'h0);
      check("rst2_overflow", {31'h0, overflow}, 32'h0);
      check("rst2_in_ready", {31'h0, in_ready}, 32'h0);
      tick();
      tick();
      #2 RESETN = 1'b1;
      for (int i = 0; i < 12; i++) begin
         tick();
         check("rst2_no_stale_intr", {31'h0, intr_out}, 32'h0);
         check("rst2_level_after", {27'h0, level}, 32'h0);
      end
      check("rst2_ready_after", {31'h0, in_ready}, 32'h1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
